// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM stage: access size encodings, the
// memory-wait FSM state type, the datapath width and the alignment rule.
package mem_wb_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Halves need an even address; words (and the 11 encoding, treated as a
  // word) need both low address bits clear. Bytes are always aligned.
  function automatic logic isMisaligned(input logic [1:0] size,
                                        input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      default: bad = (addrLo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Single-port data RAM with four byte-lane write enables and an
// asynchronous read port; lane selection and extension live in the parent.
module data_mem
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [3:0]        we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Commit only the enabled byte lanes so narrow stores leave the rest intact.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we_i[lane]) begin
        mem_q[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: branch resolution, byte/half/word
// loads and stores with optional wait states, and the registered WB bundle.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [WB_W-1:0]   control_wb_in,
  output logic              PCSrc,
  output logic              stall,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] mem_ALU_result,
  output logic [REG_W-1:0]  mem_Write_reg,
  output logic [WB_W-1:0]   mem_control_wb,
  output logic              wb_valid,
  output logic              misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  // Lane write mask for a store of the given size at the given byte offset.
  function automatic logic [3:0] laneMask(input logic [1:0] size,
                                          input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate the narrow store data across the word so any lane can take it.
  function automatic logic [DATA_W-1:0] storeData(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    d = wd;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed byte or half out of the read word and extend it.
  function automatic logic [DATA_W-1:0] loadExtend(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic [1:0] off,
                                                   input logic uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              stallNow;
  logic              accessDone;

  logic [AW-1:0]     wordIdx;
  logic [1:0]        byteOff;
  logic              memReq;
  logic              badAlign;
  logic              memAccess;
  logic              isStore;
  logic [3:0]        memWe;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic [DATA_W-1:0] loadValue;

  logic [DATA_W-1:0] readData_q, readData_d;
  logic [DATA_W-1:0] aluResult_q, aluResult_d;
  logic [REG_W-1:0]  writeReg_q, writeReg_d;
  logic [WB_W-1:0]   controlWb_q, controlWb_d;
  logic              wbValid_q, wbValid_d;
  logic              misaligned_q, misaligned_d;

  assign wordIdx   = alu_result_in[AW+1:2];
  assign byteOff   = alu_result_in[1:0];
  assign memReq    = MemRead | MemWrite;
  assign badAlign  = memReq & isMisaligned(mem_size, byteOff);
  assign memAccess = ex_valid & memReq & ~badAlign;
  assign isStore   = MemWrite & ~MemRead;

  assign PCSrc = ex_valid & Branch & Zero & ~flush;
  assign stall = stallNow;

  // Wait-state sequencing: decide whether this cycle stalls or completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stallNow   = 1'b0;
    accessDone = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memAccess) begin
            if (HAS_WAIT) begin
              state_d  = WAIT;
              cnt_d    = WS_INIT;
              stallNow = 1'b1;
            end else begin
              accessDone = 1'b1;
            end
          end
        end
        WAIT: begin
          if (!memAccess) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q != 4'd0) begin
            stallNow = 1'b1;
            cnt_d    = cnt_q - 4'd1;
          end else begin
            accessDone = 1'b1;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign memWe    = (accessDone && isStore && !reset) ? laneMask(mem_size, byteOff) : 4'b0000;
  assign memWdata = storeData(mem_size, write_data);

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_mem (
    .clk     (clk),
    .we_i    (memWe),
    .addr_i  (wordIdx),
    .wdata_i (memWdata),
    .rdata_o (memRdata)
  );

  assign loadValue = loadExtend(memRdata, mem_size, byteOff, mem_unsigned);

  // Next MEM/WB bundle: bubble, alignment fault, or the completed instruction.
  always_comb begin
    readData_d   = '0;
    aluResult_d  = '0;
    writeReg_d   = '0;
    controlWb_d  = '0;
    wbValid_d    = 1'b0;
    misaligned_d = 1'b0;
    if (flush || !ex_valid || stallNow) begin
      wbValid_d = 1'b0;
    end else if (badAlign) begin
      misaligned_d = 1'b1;
      aluResult_d  = alu_result_in;
      writeReg_d   = write_reg;
    end else begin
      wbValid_d   = 1'b1;
      controlWb_d = control_wb_in;
      aluResult_d = alu_result_in;
      writeReg_d  = write_reg;
      if (MemRead) begin
        readData_d = loadValue;
      end
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData_q   <= '0;
      aluResult_q  <= '0;
      writeReg_q   <= '0;
      controlWb_q  <= '0;
      wbValid_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      readData_q   <= readData_d;
      aluResult_q  <= aluResult_d;
      writeReg_q   <= writeReg_d;
      controlWb_q  <= controlWb_d;
      wbValid_q    <= wbValid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign read_data      = readData_q;
  assign mem_ALU_result = aluResult_q;
  assign mem_Write_reg  = writeReg_q;
  assign mem_control_wb = controlWb_q;
  assign wb_valid       = wbValid_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances (0, 3 and 2 wait states) share one
// stimulus bus; only the selected instance is checked in each phase against a
// byte-addressed memory model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, flush, Branch, Zero, MemRead, MemWrite, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] alu_result_in, write_data;
  logic [4:0]  write_reg;
  logic [1:0]  control_wb_in;

  logic        pc [3];
  logic        st [3];
  logic [31:0] rd [3];
  logic [31:0] alu [3];
  logic [4:0]  wreg [3];
  logic [1:0]  ctrl [3];
  logic        wbv [3];
  logic        mis [3];

  int sel;
  int tests  = 0;
  int failed = 0;

  logic [7:0] mb [1024];

  logic        sPc, sSt, sWbv, sMis;
  logic [31:0] sRd, sAlu;
  logic [4:0]  sWreg;
  logic [1:0]  sCtrl;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(256), .WAIT_STATES(0), .REG_W(5), .WB_W(2)) dut0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .flush(flush), .Branch(Branch),
    .Zero(Zero), .MemRead(MemRead), .MemWrite(MemWrite), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .alu_result_in(alu_result_in), .write_data(write_data),
    .write_reg(write_reg), .control_wb_in(control_wb_in), .PCSrc(pc[0]), .stall(st[0]),
    .read_data(rd[0]), .mem_ALU_result(alu[0]), .mem_Write_reg(wreg[0]),
    .mem_control_wb(ctrl[0]), .wb_valid(wbv[0]), .misaligned(mis[0]));

  mem_wb_stage #(.DEPTH(256), .WAIT_STATES(3), .REG_W(5), .WB_W(2)) dut1 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .flush(flush), .Branch(Branch),
    .Zero(Zero), .MemRead(MemRead), .MemWrite(MemWrite), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .alu_result_in(alu_result_in), .write_data(write_data),
    .write_reg(write_reg), .control_wb_in(control_wb_in), .PCSrc(pc[1]), .stall(st[1]),
    .read_data(rd[1]), .mem_ALU_result(alu[1]), .mem_Write_reg(wreg[1]),
    .mem_control_wb(ctrl[1]), .wb_valid(wbv[1]), .misaligned(mis[1]));

  mem_wb_stage #(.DEPTH(256), .WAIT_STATES(2), .REG_W(5), .WB_W(2)) dut2 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .flush(flush), .Branch(Branch),
    .Zero(Zero), .MemRead(MemRead), .MemWrite(MemWrite), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .alu_result_in(alu_result_in), .write_data(write_data),
    .write_reg(write_reg), .control_wb_in(control_wb_in), .PCSrc(pc[2]), .stall(st[2]),
    .read_data(rd[2]), .mem_ALU_result(alu[2]), .mem_Write_reg(wreg[2]),
    .mem_control_wb(ctrl[2]), .wb_valid(wbv[2]), .misaligned(mis[2]));

  // Route the selected instance's outputs to the checking signals.
  always_comb begin
    sPc   = pc[sel];
    sSt   = st[sel];
    sRd   = rd[sel];
    sAlu  = alu[sel];
    sWreg = wreg[sel];
    sCtrl = ctrl[sel];
    sWbv  = wbv[sel];
    sMis  = mis[sel];
  end

  function automatic int waitStatesOf(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 3 : 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    ex_valid = 0; flush = 0; Branch = 0; Zero = 0; MemRead = 0; MemWrite = 0;
    mem_size = 2'b10; mem_unsigned = 0; alu_result_in = 0; write_data = 0;
    write_reg = 0; control_wb_in = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd"},   sRd, 0);
    checkOutput({tag, "_alu"},  {27'd0, 5'd0} | sAlu, 0);
    checkOutput({tag, "_wreg"}, {27'd0, sWreg}, 0);
    checkOutput({tag, "_ctrl"}, {30'd0, sCtrl}, 0);
    checkOutput({tag, "_wbv"},  {31'd0, sWbv}, 0);
    checkOutput({tag, "_mis"},  {31'd0, sMis}, 0);
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  // Little-endian byte-addressed reference: load value for size/sign rules.
  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz,
                                            input logic uns);
    int unsigned ba;
    longint v;
    ba = a & 32'h3FF;
    if (sz == 2'b00) begin
      v = mb[ba];
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      v = mb[ba] + 256 * mb[ba+1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = mb[ba] + 256 * mb[ba+1] + 65536 * mb[ba+2] + 16777216 * longint'(mb[ba+3]);
    end
    return v[31:0];
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned ba;
    int n;
    logic [31:0] d;
    ba = a & 32'h3FF;
    n = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    d = wd;
    for (int i = 0; i < n; i++) begin
      mb[ba+i] = d[7:0];
      d = d >> 8;
    end
  endtask

  // Present one instruction, follow it through any stall, and check WB.
  task automatic applyStimulus(input logic ev, input logic br, input logic zr,
                               input logic mr, input logic mw, input logic [1:0] sz,
                               input logic us, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] wr,
                               input logic [1:0] cw, input logic fl);
    logic memop, bad, live;
    int expStall, nStall, bound;
    logic [31:0] expRd;
    ex_valid = ev; Branch = br; Zero = zr; MemRead = mr; MemWrite = mw;
    mem_size = sz; mem_unsigned = us; alu_result_in = addr; write_data = wd;
    write_reg = wr; control_wb_in = cw; flush = fl;

    memop = mr | mw;
    bad   = memop && ((sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00));
    live  = ev && !fl;
    expStall = (live && memop && !bad) ? waitStatesOf(sel) : 0;
    expRd = 0;
    if (live && memop && !bad) begin
      if (mr) expRd = modelLoad(addr, sz, us);
      else    modelStore(addr, sz, wd);
    end

    #1;
    checkOutput("pcsrc", {31'd0, sPc}, {31'd0, ev & br & zr & ~fl});
    nStall = 0;
    bound  = 0;
    while (sSt && bound < 20) begin
      nStall++;
      bound++;
      @(posedge clk); #1;
      checkOutput("stall_bubble_wbv",  {31'd0, sWbv}, 0);
      checkOutput("stall_bubble_ctrl", {30'd0, sCtrl}, 0);
      checkOutput("stall_bubble_mis",  {31'd0, sMis}, 0);
    end
    checkOutput("stall_cycles", nStall, expStall);
    @(posedge clk); #1;
    if (!live) begin
      checkOutput("bubble_wbv",  {31'd0, sWbv}, 0);
      checkOutput("bubble_ctrl", {30'd0, sCtrl}, 0);
      checkOutput("bubble_mis",  {31'd0, sMis}, 0);
    end else if (bad) begin
      checkOutput("misal_flag", {31'd0, sMis}, 1);
      checkOutput("misal_wbv",  {31'd0, sWbv}, 0);
      checkOutput("misal_ctrl", {30'd0, sCtrl}, 0);
      checkOutput("misal_rd",   sRd, 0);
    end else begin
      checkOutput("wb_valid", {31'd0, sWbv}, 1);
      checkOutput("wb_mis",   {31'd0, sMis}, 0);
      checkOutput("wb_ctrl",  {30'd0, sCtrl}, {30'd0, cw});
      checkOutput("wb_alu",   sAlu, addr);
      checkOutput("wb_reg",   {27'd0, sWreg}, {27'd0, wr});
      checkOutput("wb_rd",    sRd, expRd);
    end
  endtask

  task automatic storeWord(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1, 0, 0, 0, 1, 2'b10, 0, a, d, 5'd0, 2'b00, 0);
  endtask

  task automatic loadWord(input logic [31:0] a);
    applyStimulus(1, 0, 0, 1, 0, 2'b10, 0, a, 32'd0, 5'd9, 2'b11, 0);
  endtask

  task automatic randomPhase(input int nOps);
    logic [31:0] a;
    logic [1:0]  sz;
    int kind;
    for (int w = 0; w < 16; w++) storeWord(32'(w * 4), $urandom);
    for (int i = 0; i < nOps; i++) begin
      sz   = 2'($urandom_range(0, 3));
      a    = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      kind = $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
                    (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                    sz, 1'($urandom), a, $urandom, 5'($urandom), 2'($urandom),
                    $urandom_range(0, 14) == 0);
    end
  endtask

  initial begin
    sel = 0;
    idleInputs();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkAllZero("reset0");
    checkOutput("reset0_stall", {31'd0, sSt}, 0);
    reset = 0;

    // Zero wait states: word store/load, narrow store and signed/unsigned loads.
    storeWord(32'h20, 32'hDEADBEEF);
    loadWord(32'h20);
    checkOutput("lw20_const", sRd, 32'hDEADBEEF);
    applyStimulus(1, 0, 0, 0, 1, 2'b00, 0, 32'h21, 32'h00000080, 5'd0, 2'b00, 0);
    applyStimulus(1, 0, 0, 1, 0, 2'b00, 0, 32'h21, 32'd0, 5'd3, 2'b01, 0);
    checkOutput("lb21_const", sRd, 32'hFFFFFF80);
    applyStimulus(1, 0, 0, 1, 0, 2'b00, 1, 32'h21, 32'd0, 5'd4, 2'b01, 0);
    checkOutput("lbu21_const", sRd, 32'h00000080);
    loadWord(32'h20);
    checkOutput("lw20_merged", sRd, 32'hDEAD80EF);
    applyStimulus(1, 0, 0, 1, 1, 2'b10, 0, 32'h20, 32'h12345678, 5'd5, 2'b10, 0);
    checkOutput("rw_both_reads", sRd, 32'hDEAD80EF);
    loadWord(32'h20);
    checkOutput("rw_write_suppressed", sRd, 32'hDEAD80EF);

    // Branch resolution and flush masking.
    ex_valid = 1; Branch = 1; Zero = 1; flush = 0;
    #1;
    checkOutput("pcsrc_taken", {31'd0, sPc}, 1);
    flush = 1;
    #1;
    checkOutput("pcsrc_flushed", {31'd0, sPc}, 0);
    idleInputs();
    @(posedge clk); #1;
    randomPhase(40);

    // Three wait states: stalled load and misaligned access.
    sel = 1;
    doReset();
    checkAllZero("reset1");
    storeWord(32'h20, 32'hCAFEF00D);
    loadWord(32'h20);
    checkOutput("ws3_lw_const", sRd, 32'hCAFEF00D);
    loadWord(32'h22);
    checkOutput("ws3_misal_const", {31'd0, sMis}, 1);
    loadWord(32'h20);
    checkOutput("ws3_unchanged", sRd, 32'hCAFEF00D);
    randomPhase(30);

    // Two wait states: flush on completion, then reset in the first wait cycle.
    sel = 2;
    doReset();
    storeWord(32'h40, 32'h11112222);
    ex_valid = 1; MemWrite = 1; MemRead = 0; mem_size = 2'b10;
    alu_result_in = 32'h40; write_data = 32'h99998888; flush = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checkOutput("flushcase_stall", {31'd0, sSt}, 1);
      @(posedge clk);
    end
    #1;
    flush = 1;
    #1;
    checkOutput("flushcase_nostall", {31'd0, sSt}, 0);
    @(posedge clk); #1;
    checkOutput("flushcase_bubble", {31'd0, sWbv}, 0);
    idleInputs();
    loadWord(32'h40);
    checkOutput("flushcase_old", sRd, 32'h11112222);

    ex_valid = 1; MemWrite = 1; MemRead = 0; mem_size = 2'b10;
    alu_result_in = 32'h40; write_data = 32'h77776666;
    #1;
    @(posedge clk); #1;
    checkOutput("resetcase_wait_stall", {31'd0, sSt}, 1);
    reset = 1;
    @(posedge clk); #1;
    checkAllZero("resetcase");
    idleInputs();
    reset = 0;
    #1;
    checkOutput("resetcase_stall", {31'd0, sSt}, 0);
    loadWord(32'h40);
    checkOutput("resetcase_old", sRd, 32'h11112222);
    randomPhase(30);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
